// File: rtl/regfile_bus_master_pkg.sv
// Shared types and helpers for the register-file bus master.
package regfile_bus_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        WAIT,
        RESP
    } state_t;

    localparam int LANES  = 4;
    localparam int LANE_W = 32;
    localparam int BUS_W  = 128;
    localparam int WE_W   = BUS_W / 8;

    // Byte enables for one 32-bit lane placed within the 128-bit word.
    function automatic logic [WE_W-1:0] lane_we(input logic [3:0] strb, input logic [1:0] lane);
        return {12'h0, strb} << (4 * lane);
    endfunction

endpackage

// File: rtl/regfile_bus_master_if.sv
// Command/response handshake plus 128-bit memory port; master = the bus master block.
interface regfile_bus_master_if #(
    parameter int ADDR_W = 16
);
    import regfile_bus_pkg::*;

    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_write;
    logic [ADDR_W-1:0] cmd_addr;
    logic [LANE_W-1:0] cmd_wdata;
    logic [3:0]        cmd_wstrb;

    logic              rsp_valid;
    logic              rsp_ready;
    logic [LANE_W-1:0] rsp_rdata;
    logic              rsp_err;

    logic [ADDR_W-1:0] mem_addr;
    logic              mem_en;
    logic [WE_W-1:0]   mem_we;
    logic [BUS_W-1:0]  mem_wr_data;
    logic [BUS_W-1:0]  mem_rd_data;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_wstrb,
        output cmd_ready,
        output rsp_valid, rsp_rdata, rsp_err,
        input  rsp_ready,
        output mem_addr, mem_en, mem_we, mem_wr_data,
        input  mem_rd_data
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_wstrb,
        input  cmd_ready,
        input  rsp_valid, rsp_rdata, rsp_err,
        output rsp_ready,
        input  mem_addr, mem_en, mem_we, mem_wr_data,
        output mem_rd_data
    );

endinterface

// File: rtl/regfile_bus_master.sv
// Bridges single 32-bit read/write commands onto a 128-bit BRAM-style register-file port.
// Latency after acceptance: error response T+1, write T+2, read T+2+RD_LAT.
// Backpressure: one command in flight; cmd_ready low until the response is taken, response held while rsp_ready low.
module regfile_bus_master
    import regfile_bus_pkg::*;
#(
    parameter int                ADDR_W     = 16,
    parameter int                RD_LAT     = 1,
    parameter logic [ADDR_W-1:0] ADDR_LIMIT = 'h40
) (
    input  logic                  clk,
    input  logic                  rst,
    regfile_bus_master_if.master  bus
);

    state_t     state;
    logic       write_q;
    logic [1:0] lane_q;
    logic [2:0] wait_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= IDLE;
            write_q         <= 1'b0;
            lane_q          <= 2'd0;
            wait_cnt        <= 3'd0;
            bus.cmd_ready   <= 1'b1;
            bus.rsp_valid   <= 1'b0;
            bus.rsp_rdata   <= '0;
            bus.rsp_err     <= 1'b0;
            bus.mem_en      <= 1'b0;
            bus.mem_we      <= '0;
            bus.mem_addr    <= '0;
            bus.mem_wr_data <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.cmd_valid) begin
                        bus.cmd_ready <= 1'b0;
                        lane_q        <= bus.cmd_addr[3:2];
                        write_q       <= bus.cmd_write;
                        bus.rsp_rdata <= '0;
                        // Out-of-range commands skip the memory entirely.
                        if (bus.cmd_addr >= ADDR_LIMIT) begin
                            bus.rsp_err   <= 1'b1;
                            bus.rsp_valid <= 1'b1;
                            state         <= RESP;
                        end else begin
                            bus.rsp_err     <= 1'b0;
                            bus.mem_en      <= 1'b1;
                            bus.mem_we      <= bus.cmd_write ? lane_we(bus.cmd_wstrb, bus.cmd_addr[3:2]) : '0;
                            bus.mem_addr    <= {bus.cmd_addr[ADDR_W-1:4], 4'h0};
                            bus.mem_wr_data <= {LANES{bus.cmd_wdata}};
                            state           <= ACCESS;
                        end
                    end
                end
                ACCESS: begin
                    bus.mem_en <= 1'b0;
                    bus.mem_we <= '0;
                    if (write_q) begin
                        bus.rsp_valid <= 1'b1;
                        state         <= RESP;
                    end else begin
                        wait_cnt <= 3'(RD_LAT - 1);
                        state    <= WAIT;
                    end
                end
                WAIT: begin
                    // Count reaches zero in the cycle the memory presents read data.
                    if (wait_cnt == 3'd0) begin
                        bus.rsp_rdata <= bus.mem_rd_data[LANE_W*int'(lane_q) +: LANE_W];
                        bus.rsp_valid <= 1'b1;
                        state         <= RESP;
                    end else begin
                        wait_cnt <= wait_cnt - 3'd1;
                    end
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        bus.rsp_valid <= 1'b0;
                        bus.cmd_ready <= 1'b1;
                        state         <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_regfile_bus_master.sv
// Randomized and directed bench for regfile_bus_master against a word-level memory model.
module tb_regfile_bus_master;
    import regfile_bus_pkg::*;

    localparam int          ADDR_W     = 16;
    localparam int          RD_LAT     = 2;
    localparam logic [15:0] ADDR_LIMIT = 16'h0040;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    regfile_bus_master_if #(.ADDR_W(ADDR_W)) bus();

    regfile_bus_master #(
        .ADDR_W    (ADDR_W),
        .RD_LAT    (RD_LAT),
        .ADDR_LIMIT(ADDR_LIMIT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference: sixteen 32-bit words, byte address >> 2.
    logic [31:0]  ref_mem  [16];
    logic [127:0] init_mem [4];

    // Memory environment: byte-enabled writes, reads valid RD_LAT cycles after mem_en.
    logic [127:0] mem     [4];
    logic [127:0] rd_pipe [1:RD_LAT];
    always @(posedge clk) begin
        if (cyc == 0) begin
            for (int i = 0; i < 4; i++) mem[i] <= init_mem[i];
        end else if (bus.mem_en === 1'b1) begin
            for (int i = 0; i < 16; i++)
                if (bus.mem_we[i]) mem[bus.mem_addr[5:4]][8*i +: 8] <= bus.mem_wr_data[8*i +: 8];
        end
        rd_pipe[1] <= (bus.mem_en === 1'b1 && bus.mem_we == 16'h0) ? mem[bus.mem_addr[5:4]]
                                                                  : {$urandom, $urandom, $urandom, $urandom};
        for (int i = 2; i <= RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
    assign bus.mem_rd_data = rd_pipe[RD_LAT];

    int en_total = 0;
    int we_viol  = 0;
    always @(negedge clk) begin
        if (rst === 1'b0) begin
            if (bus.mem_en === 1'b1) en_total++;
            if (bus.mem_we !== 16'h0 && bus.mem_en !== 1'b1) we_viol++;
        end
    end

    function automatic logic [15:0] exp_we(input logic [15:0] addr, input logic [3:0] ws);
        logic [15:0] r;
        r = 16'h0;
        for (int b = 0; b < 4; b++)
            if (ws[b]) r[int'(addr[3:2]) * 4 + b] = 1'b1;
        return r;
    endfunction

    task automatic ref_write(input logic [15:0] addr, input logic [31:0] wd, input logic [3:0] ws);
        for (int b = 0; b < 4; b++)
            if (ws[b]) ref_mem[addr[5:2]][8*b +: 8] = wd[8*b +: 8];
    endtask

    // Issues one command with rsp_ready high and reports what the bus did.
    task automatic drive_cmd(input logic wr, input logic [15:0] addr, input logic [31:0] wd,
                             input logic [3:0] ws, output int lat, output logic [31:0] rdata,
                             output logic err, output int en_n, output int en_at,
                             output logic [15:0] we_s, output logic [15:0] addr_s,
                             output logic [127:0] wd_s, output int acc);
        int guard;
        lat = -1; en_n = 0; en_at = -1; we_s = '0; addr_s = '0; wd_s = '0;
        rdata = '0; err = 1'b0; acc = -1;
        @(negedge clk);
        bus.cmd_valid = 1'b1; bus.cmd_write = wr; bus.cmd_addr = addr;
        bus.cmd_wdata = wd;   bus.cmd_wstrb = ws; bus.rsp_ready = 1'b1;
        guard = 0;
        while (bus.cmd_ready !== 1'b1 && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 50) begin
            bus.cmd_valid = 1'b0;
            return;
        end
        acc = cyc;
        @(posedge clk);
        for (int n = 1; n <= 20; n++) begin
            @(negedge clk);
            if (n == 1) bus.cmd_valid = 1'b0;
            if (bus.mem_en === 1'b1) begin
                en_n++; en_at = n; we_s = bus.mem_we; addr_s = bus.mem_addr; wd_s = bus.mem_wr_data;
            end
            if (bus.rsp_valid === 1'b1) begin
                lat = n; rdata = bus.rsp_rdata; err = bus.rsp_err;
                break;
            end
        end
        @(posedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.cmd_valid = 1'b0; bus.cmd_write = 1'b0; bus.cmd_addr = '0;
        bus.cmd_wdata = '0;   bus.cmd_wstrb = '0;   bus.rsp_ready = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (bus.cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_cmd_ready: got %b want 1", bus.cmd_ready); end
        checks++; if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid: got %b want 0", bus.rsp_valid); end
        checks++; if ({bus.rsp_rdata, bus.rsp_err} !== 33'h0) begin errors++; $display("FAIL reset_rsp_data: got %h/%b want 0/0", bus.rsp_rdata, bus.rsp_err); end
        checks++; if ({bus.mem_en, bus.mem_we, bus.mem_addr} !== 33'h0) begin errors++; $display("FAIL reset_mem_ctl: en=%b we=%h addr=%h want all 0", bus.mem_en, bus.mem_we, bus.mem_addr); end
        checks++; if (bus.mem_wr_data !== 128'h0) begin errors++; $display("FAIL reset_mem_wr_data: got %h want 0", bus.mem_wr_data); end
        rst = 1'b0;
    endtask

    task automatic test_write_lane2();
        int lat, en_n, en_at, acc; logic [31:0] rd; logic er; logic [15:0] we_s, a_s; logic [127:0] wd_s;
        drive_cmd(1'b1, 16'h0028, 32'hA5A5_1234, 4'hF, lat, rd, er, en_n, en_at, we_s, a_s, wd_s, acc);
        ref_write(16'h0028, 32'hA5A5_1234, 4'hF);
        checks++; if (en_n !== 1 || en_at !== 1) begin errors++; $display("FAIL wr_en_timing: count=%0d at=%0d want 1 at 1", en_n, en_at); end
        checks++; if (a_s !== 16'h0020) begin errors++; $display("FAIL wr_mem_addr: got %h want 0020", a_s); end
        checks++; if (we_s !== 16'h0F00) begin errors++; $display("FAIL wr_mem_we: got %h want 0f00", we_s); end
        checks++; if (wd_s !== {4{32'hA5A5_1234}}) begin errors++; $display("FAIL wr_mem_wr_data: got %h", wd_s); end
        checks++; if (lat !== 2) begin errors++; $display("FAIL wr_latency: got %0d want 2", lat); end
        checks++; if (er !== 1'b0 || rd !== 32'h0) begin errors++; $display("FAIL wr_rsp: err=%b rdata=%h want 0/0", er, rd); end
    endtask

    task automatic test_read_lane2();
        int lat, en_n, en_at, acc; logic [31:0] rd; logic er; logic [15:0] we_s, a_s; logic [127:0] wd_s;
        drive_cmd(1'b0, 16'h0028, 32'h0, 4'h0, lat, rd, er, en_n, en_at, we_s, a_s, wd_s, acc);
        checks++; if (en_n !== 1 || en_at !== 1 || we_s !== 16'h0) begin errors++; $display("FAIL rd_en: count=%0d at=%0d we=%h want 1 at 1 we 0", en_n, en_at, we_s); end
        checks++; if (lat !== 2 + RD_LAT) begin errors++; $display("FAIL rd_latency: got %0d want %0d", lat, 2 + RD_LAT); end
        checks++; if (rd !== 32'hA5A5_1234 || er !== 1'b0) begin errors++; $display("FAIL rd_data: got %h err=%b want a5a51234/0", rd, er); end
    endtask

    task automatic test_partial_strobe();
        int lat, en_n, en_at, acc; logic [31:0] rd, wd, expd; logic er; logic [15:0] we_s, a_s; logic [127:0] wd_s;
        wd = $urandom;
        expd = {ref_mem[1][31:24], wd[23:8], ref_mem[1][7:0]};
        drive_cmd(1'b1, 16'h0004, wd, 4'b0110, lat, rd, er, en_n, en_at, we_s, a_s, wd_s, acc);
        ref_write(16'h0004, wd, 4'b0110);
        checks++; if (we_s !== 16'h0060) begin errors++; $display("FAIL strb_we: got %h want 0060", we_s); end
        drive_cmd(1'b0, 16'h0004, 32'h0, 4'h0, lat, rd, er, en_n, en_at, we_s, a_s, wd_s, acc);
        checks++; if (rd !== expd) begin errors++; $display("FAIL strb_merge: got %h want %h", rd, expd); end
    endtask

    task automatic test_addr_limit();
        int lat, en_n, en_at, acc, en0; logic [31:0] rd; logic er; logic [15:0] we_s, a_s; logic [127:0] wd_s;
        en0 = en_total;
        drive_cmd(1'b0, ADDR_LIMIT, 32'h0, 4'h0, lat, rd, er, en_n, en_at, we_s, a_s, wd_s, acc);
        checks++; if (lat !== 1) begin errors++; $display("FAIL lim_latency: got %0d want 1", lat); end
        checks++; if (er !== 1'b1 || rd !== 32'h0) begin errors++; $display("FAIL lim_rsp: err=%b rdata=%h want 1/0", er, rd); end
        drive_cmd(1'b1, 16'hFFFC, 32'hDEAD_BEEF, 4'hF, lat, rd, er, en_n, en_at, we_s, a_s, wd_s, acc);
        checks++; if (er !== 1'b1 || lat !== 1) begin errors++; $display("FAIL lim_write: err=%b lat=%0d want 1/1", er, lat); end
        checks++; if (en_total !== en0) begin errors++; $display("FAIL lim_no_mem: mem_en cycles %0d want %0d", en_total, en0); end
        drive_cmd(1'b0, ADDR_LIMIT - 16'd4, 32'h0, 4'h0, lat, rd, er, en_n, en_at, we_s, a_s, wd_s, acc);
        checks++; if (er !== 1'b0 || rd !== ref_mem[15]) begin errors++; $display("FAIL lim_last_ok: err=%b rdata=%h want 0/%h", er, rd, ref_mem[15]); end
    endtask

    task automatic test_wstrb_zero();
        int lat, en_n, en_at, acc; logic [31:0] rd; logic er; logic [15:0] we_s, a_s; logic [127:0] wd_s;
        drive_cmd(1'b1, 16'h0030, 32'h1234_5678, 4'h0, lat, rd, er, en_n, en_at, we_s, a_s, wd_s, acc);
        checks++; if (en_n !== 1 || we_s !== 16'h0) begin errors++; $display("FAIL zstrb_access: count=%0d we=%h want 1/0", en_n, we_s); end
        checks++; if (er !== 1'b0 || lat !== 2) begin errors++; $display("FAIL zstrb_rsp: err=%b lat=%0d want 0/2", er, lat); end
    endtask

    task automatic test_backpressure();
        int guard, en0; logic [31:0] first;
        en0 = en_total;
        @(negedge clk);
        bus.cmd_valid = 1'b1; bus.cmd_write = 1'b0; bus.cmd_addr = 16'h0008; bus.rsp_ready = 1'b0;
        guard = 0;
        while (bus.cmd_ready !== 1'b1 && guard < 50) begin @(negedge clk); guard++; end
        @(posedge clk);
        @(negedge clk);
        bus.cmd_write = 1'b1; bus.cmd_addr = 16'h000C; bus.cmd_wdata = 32'hCAFE_F00D; bus.cmd_wstrb = 4'hF;
        guard = 0;
        while (bus.rsp_valid !== 1'b1 && guard < 20) begin @(negedge clk); guard++; end
        checks++; if (guard >= 20) begin errors++; $display("FAIL bp_rsp_timeout: no response within %0d cycles", guard); end
        first = bus.rsp_rdata;
        checks++; if (first !== ref_mem[2]) begin errors++; $display("FAIL bp_rdata: got %h want %h", first, ref_mem[2]); end
        for (int k = 1; k <= 10; k++) begin
            checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_rdata !== first) begin errors++; $display("FAIL bp_hold[%0d]: valid=%b rdata=%h", k, bus.rsp_valid, bus.rsp_rdata); end
            checks++; if (bus.cmd_ready !== 1'b0) begin errors++; $display("FAIL bp_cmd_ready[%0d]: got %b want 0", k, bus.cmd_ready); end
            if (k < 10) @(negedge clk);
        end
        @(negedge clk);
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        checks++; if (bus.cmd_ready !== 1'b1 || bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL bp_release: cmd_ready=%b rsp_valid=%b want 1/0", bus.cmd_ready, bus.rsp_valid); end
        checks++; if (en_total !== en0 + 1) begin errors++; $display("FAIL bp_pending_taken: mem_en cycles %0d want %0d", en_total, en0 + 1); end
    endtask

    task automatic test_reset_in_wait();
        int guard, seen, lat, en_n, en_at, acc; logic [31:0] rd; logic er; logic [15:0] we_s, a_s; logic [127:0] wd_s;
        @(negedge clk);
        bus.cmd_valid = 1'b1; bus.cmd_write = 1'b0; bus.cmd_addr = 16'h0014; bus.rsp_ready = 1'b1;
        guard = 0;
        while (bus.cmd_ready !== 1'b1 && guard < 50) begin @(negedge clk); guard++; end
        @(posedge clk);
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checks++; if (bus.cmd_ready !== 1'b1 || bus.rsp_valid !== 1'b0 || bus.rsp_rdata !== 32'h0 || bus.rsp_err !== 1'b0) begin errors++; $display("FAIL rstw_rsp: ready=%b valid=%b rdata=%h err=%b", bus.cmd_ready, bus.rsp_valid, bus.rsp_rdata, bus.rsp_err); end
        checks++; if (bus.mem_en !== 1'b0 || bus.mem_we !== 16'h0 || bus.mem_addr !== 16'h0 || bus.mem_wr_data !== 128'h0) begin errors++; $display("FAIL rstw_mem: en=%b we=%h addr=%h", bus.mem_en, bus.mem_we, bus.mem_addr); end
        rst = 1'b0;
        seen = 0;
        repeat (8) begin @(negedge clk); if (bus.rsp_valid === 1'b1) seen++; end
        checks++; if (seen !== 0) begin errors++; $display("FAIL rstw_no_rsp: %0d response cycles want 0", seen); end
        drive_cmd(1'b1, 16'h0018, 32'h0BAD_F00D, 4'hF, lat, rd, er, en_n, en_at, we_s, a_s, wd_s, acc);
        ref_write(16'h0018, 32'h0BAD_F00D, 4'hF);
        checks++; if (lat !== 2 || er !== 1'b0 || we_s !== 16'h0F00) begin errors++; $display("FAIL rstw_after_write: lat=%0d err=%b we=%h want 2/0/0f00", lat, er, we_s); end
    endtask

    task automatic test_back_to_back();
        int lat, en_n, en_at, a0, a1, a2, a3; logic [31:0] rd; logic er; logic [15:0] we_s, a_s; logic [127:0] wd_s;
        drive_cmd(1'b1, 16'h0010, 32'h1111_1111, 4'hF, lat, rd, er, en_n, en_at, we_s, a_s, wd_s, a0);
        drive_cmd(1'b1, 16'h0020, 32'h2222_2222, 4'hF, lat, rd, er, en_n, en_at, we_s, a_s, wd_s, a1);
        drive_cmd(1'b0, 16'h0010, 32'h0, 4'h0, lat, rd, er, en_n, en_at, we_s, a_s, wd_s, a2);
        drive_cmd(1'b0, 16'h0020, 32'h0, 4'h0, lat, rd, er, en_n, en_at, we_s, a_s, wd_s, a3);
        ref_write(16'h0010, 32'h1111_1111, 4'hF);
        ref_write(16'h0020, 32'h2222_2222, 4'hF);
        checks++; if (a1 - a0 !== 3 || a2 - a1 !== 3) begin errors++; $display("FAIL b2b_write_gap: %0d,%0d want 3,3", a1 - a0, a2 - a1); end
        checks++; if (a3 - a2 !== 3 + RD_LAT) begin errors++; $display("FAIL b2b_read_gap: %0d want %0d", a3 - a2, 3 + RD_LAT); end
        checks++; if (rd !== 32'h2222_2222) begin errors++; $display("FAIL b2b_read_data: got %h want 22222222", rd); end
    endtask

    task automatic test_random();
        int lat, en_n, en_at, acc, exp_lat; logic [31:0] rd, wd, exp_rd; logic er, wr, exp_err;
        logic [15:0] we_s, a_s, addr, exp_w; logic [127:0] wd_s; logic [3:0] ws;
        for (int it = 0; it < 40; it++) begin
            wr   = 1'($urandom_range(0, 1));
            addr = 16'($urandom_range(0, 16'h004F));
            wd   = $urandom;
            ws   = 4'($urandom_range(0, 15));
            exp_err = (addr >= ADDR_LIMIT);
            exp_lat = exp_err ? 1 : (wr ? 2 : 2 + RD_LAT);
            exp_rd  = (exp_err || wr) ? 32'h0 : ref_mem[addr[5:2]];
            exp_w   = (wr && !exp_err) ? exp_we(addr, ws) : 16'h0;
            drive_cmd(wr, addr, wd, ws, lat, rd, er, en_n, en_at, we_s, a_s, wd_s, acc);
            if (wr && !exp_err) ref_write(addr, wd, ws);
            checks++; if (lat !== exp_lat || er !== exp_err) begin errors++; $display("FAIL rnd_rsp[%0d] addr=%h wr=%b: lat=%0d err=%b want %0d/%b", it, addr, wr, lat, er, exp_lat, exp_err); end
            checks++; if (rd !== exp_rd) begin errors++; $display("FAIL rnd_rdata[%0d] addr=%h: got %h want %h", it, addr, rd, exp_rd); end
            checks++; if (en_n !== (exp_err ? 0 : 1) || we_s !== exp_w) begin errors++; $display("FAIL rnd_mem[%0d] addr=%h: en=%0d we=%h want we %h", it, addr, en_n, we_s, exp_w); end
        end
        checks++; if (we_viol !== 0) begin errors++; $display("FAIL we_outside_access: %0d cycles want 0", we_viol); end
    endtask

    initial begin
        for (int i = 0; i < 16; i++) begin
            ref_mem[i] = $urandom;
            init_mem[i/4][32*(i%4) +: 32] = ref_mem[i];
        end
        test_reset();
        test_write_lane2();
        test_read_lane2();
        test_partial_strobe();
        test_addr_limit();
        test_wstrb_zero();
        test_backpressure();
        test_reset_in_wait();
        test_back_to_back();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

endmodule

// File: doc/regfile_bus_master.md
Name: regfile_bus_master

Overview:
- Initiator side of the 128-bit BRAM-style register-file port.
- Turns single 32-bit read/write commands (valid/ready) into memory-port cycles: en, we[15:0], addr, wr_data, rd_data. Returns one response per command.
- Lets fabric logic (e.g. a UART command parser) drive mem_regfile the same way the processor's BRAM controller does.

Parameters:
- ADDR_W, 16: byte-address width of cmd_addr and mem_addr.
- RD_LAT, 1: cycles from mem_en (read) to valid mem_rd_data; range 1..4.
- ADDR_LIMIT, 16'h0040: byte addresses >= ADDR_LIMIT are rejected with an error response.

Ports:
- clk, in, 1: single clock for all logic.
- rst, in, 1: synchronous, active-high reset.
- cmd_valid, in, 1: command present.
- cmd_ready, out, 1: block accepts a command this cycle.
- cmd_write, in, 1: 1 = write, 0 = read.
- cmd_addr, in, ADDR_W: byte address; bits [1:0] ignored.
- cmd_wdata, in, 32: write data.
- cmd_wstrb, in, 4: byte enables for a write.
- rsp_valid, out, 1: response present.
- rsp_ready, in, 1: consumer takes the response.
- rsp_rdata, out, 32: read data; 0 for writes.
- rsp_err, out, 1: address out of range.
- mem_addr, out, ADDR_W: memory address = {cmd_addr[ADDR_W-1:4], 4'h0}.
- mem_en, out, 1: memory enable.
- mem_we, out, 16: per-byte write enables.
- mem_wr_data, out, 128: cmd_wdata replicated into all four lanes.
- mem_rd_data, in, 128: memory read data.

Behaviour:
- Reset:
  - State IDLE.
  - cmd_ready=1 (IDLE only); rsp_valid=0, rsp_rdata=0, rsp_err=0.
  - mem_en=0, mem_we=0, mem_addr=0, mem_wr_data=0.
  - Reset in any state aborts the operation; no response is issued for it.
- Lane and strobes:
  - lane = cmd_addr[3:2].
  - mem_we = {12'h0, cmd_wstrb} << (4*lane).
  - Read data = mem_rd_data[32*lane +: 32]; lane is latched at acceptance.
- All mem_* outputs and rsp_* outputs are registered.
- FSM states:
  - IDLE: cmd_ready=1. On cmd_valid, latch the command (acceptance cycle T).
    - Out-of-range address -> RESP with rsp_err=1, rsp_rdata=0. No memory cycle occurs.
    - Write -> ACCESS.
    - Read -> ACCESS.
  - ACCESS (T+1): mem_en=1 for exactly one cycle, addr/data valid; mem_we = strobes for a write, 0 for a read.
    - Write -> RESP.
    - Read -> WAIT.
  - WAIT: counter runs RD_LAT cycles. In the cycle where mem_rd_data is valid (T+1+RD_LAT), capture the lane into rsp_rdata -> RESP.
  - RESP: rsp_valid=1, holding rsp_rdata/rsp_err stable until rsp_valid && rsp_ready -> IDLE.
- Latency:
  - Write: rsp_valid at T+2.
  - Read: rsp_valid at T+2+RD_LAT.
  - Error: rsp_valid at T+1.
  - Command throughput: one per (latency + 1) cycles minimum; cmd_ready is reasserted the cycle after the response handshake.
- Boundary cases:
  - cmd_wstrb=0 on a write: still runs an ACCESS cycle with mem_en=1, mem_we=0, and acks with rsp_err=0.
  - cmd_valid while not IDLE: ignored (cmd_ready=0); the command must stay held by the source.
  - rsp_ready held low indefinitely: stays in RESP, response outputs unchanged.
  - Address ADDR_LIMIT-4 is accepted; ADDR_LIMIT is rejected.
  - mem_en is never asserted outside ACCESS; mem_we is nonzero only in a write ACCESS.

Decomposition:
- Package regfile_bus_pkg:
  - state enum {IDLE, ACCESS, WAIT, RESP}.
  - LANES=4, LANE_W=32, BUS_W=128.
  - Function lane_we(strb, lane) returning 16-bit enables.
- No sub-module: the FSM, latency counter and lane mux are small enough for one module.

Test Plan:
- Write addr 16'h0028 (lane 2), wdata 32'hA5A5_1234, wstrb 4'hF, rsp_ready=1 -> at T+1: mem_en=1, mem_addr=16'h0020, mem_we=16'h0F00, mem_wr_data = 4 copies of A5A51234; rsp_valid at T+2, rsp_err=0.
- Read addr 16'h0028 with RD_LAT=2 and a model memory returning lane 2 = 32'hA5A5_1234 -> mem_en only at T+1 with mem_we=0; rsp_valid at T+4, rsp_rdata=32'hA5A5_1234.
- Write addr 16'h0004, wstrb 4'b0110 -> mem_we=16'h0060; a following read of 16'h0004 returns old bytes 3 and 0 with new bytes 2 and 1.
- Read addr 16'h0040 (ADDR_LIMIT) -> no mem_en ever; rsp_valid at T+1, rsp_err=1, rsp_rdata=0. Read 16'h003C succeeds.
- rsp_ready low for 10 cycles on a read -> rsp_valid and rsp_rdata stable throughout, cmd_ready=0, a pending cmd_valid is not taken; the handshake on cycle 11 is followed by cmd_ready=1 on the next cycle.
- rst pulsed during WAIT -> next cycle all outputs at reset values, no response emitted; a subsequent write completes normally.
